// File: rtl/mips32_5stage_core.sv
`default_nettype none
// =============================================================================
// Module   : mips32_5stage_core
// Brief    : MIPS-subset 5-stage pipeline (IF/ID/EX/MEM/WB) with forwarding,
//            load-use stall, beq resolved in EX and j resolved in ID.
//            Define IMM_ALU_EN to add addi/slti/andi/ori.
// Revision : 1.0 - initial release
// =============================================================================
module mips32_5stage_core #(
  parameter int DMEM_DEPTH = 32,
  parameter int PC_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_i,
  output logic [31:0] inst_mem_rd_addr_to_instmem
);

  localparam int         c_DMEM_AW = $clog2(DMEM_DEPTH);
  localparam logic [2:0] c_ALU_ADD = 3'd0;
  localparam logic [2:0] c_ALU_SUB = 3'd1;
  localparam logic [2:0] c_ALU_AND = 3'd2;
  localparam logic [2:0] c_ALU_OR  = 3'd3;
  localparam logic [2:0] c_ALU_SLT = 3'd4;

  typedef struct packed {
    logic            reg_wr;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic            use_imm;
    logic [2:0]      alu_op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dst;
    logic [31:0]     rs_val;
    logic [31:0]     rt_val;
    logic [31:0]     imm;
    logic [PC_W-1:0] pc1;
  } idex_t;

  typedef struct packed {
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic [4:0]  dst;
    logic [31:0] alu_res;
    logic [31:0] store_val;
  } exmem_t;

  typedef struct packed {
    logic        reg_wr;
    logic [4:0]  dst;
    logic [31:0] wb_val;
  } memwb_t;

  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ifid_instr;
  logic [PC_W-1:0] r_ifid_pc1;
  idex_t           r_idex;
  exmem_t          r_exmem;
  memwb_t          r_memwb;
  logic [31:0]     r_regs [32];
  logic [31:0]     r_dmem [DMEM_DEPTH];

  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [15:0]     w_imm;
  logic [31:0]     w_rs_val;
  logic [31:0]     w_rt_val;
  idex_t           w_dec;
  logic            w_use_rs;
  logic            w_use_rt;
  logic            w_jump;
  logic            w_wr;
  logic            w_stall;
  logic            w_take;
  logic            w_jump_go;
  logic [PC_W-1:0] w_jpc;
  logic [31:0]     w_jpc32;
  logic [PC_W-1:0] w_jtarget;
  logic [PC_W-1:0] w_btarget;
  logic [31:0]     w_fwd_a;
  logic [31:0]     w_fwd_b;
  logic [31:0]     w_alu_b;
  logic [31:0]     w_alu_res;
  logic [31:0]     w_mem_rdata;

  assign inst_mem_rd_addr_to_instmem = 32'(r_pc);

  // ---------------- ID: field split, regfile read with WB write-through
  assign w_op    = r_ifid_instr[31:26];
  assign w_rs    = r_ifid_instr[25:21];
  assign w_rt    = r_ifid_instr[20:16];
  assign w_rd    = r_ifid_instr[15:11];
  assign w_funct = r_ifid_instr[5:0];
  assign w_imm   = r_ifid_instr[15:0];

  assign w_rs_val = (r_memwb.reg_wr && r_memwb.dst == w_rs) ? r_memwb.wb_val : r_regs[w_rs];
  assign w_rt_val = (r_memwb.reg_wr && r_memwb.dst == w_rt) ? r_memwb.wb_val : r_regs[w_rt];

  always_comb begin
    w_dec          = '0;
    w_use_rs       = 1'b0;
    w_use_rt       = 1'b0;
    w_jump         = 1'b0;
    w_wr           = 1'b0;
    w_dec.rs       = w_rs;
    w_dec.rt       = w_rt;
    w_dec.dst      = w_rt;
    w_dec.rs_val   = w_rs_val;
    w_dec.rt_val   = w_rt_val;
    w_dec.imm      = {{16{w_imm[15]}}, w_imm};
    w_dec.pc1      = r_ifid_pc1;
    w_dec.alu_op   = c_ALU_ADD;
    case (w_op)
      6'd0: begin
        w_use_rs  = 1'b1;
        w_use_rt  = 1'b1;
        w_wr      = 1'b1;
        w_dec.dst = w_rd;
        case (w_funct)
          6'h20:   w_dec.alu_op = c_ALU_ADD;
          6'h22:   w_dec.alu_op = c_ALU_SUB;
          6'h24:   w_dec.alu_op = c_ALU_AND;
          6'h25:   w_dec.alu_op = c_ALU_OR;
          6'h2A:   w_dec.alu_op = c_ALU_SLT;
          default: begin
            w_use_rs = 1'b0;
            w_use_rt = 1'b0;
            w_wr     = 1'b0;
          end
        endcase
      end
      6'd35: begin
        w_use_rs      = 1'b1;
        w_wr          = 1'b1;
        w_dec.mem_rd  = 1'b1;
        w_dec.use_imm = 1'b1;
      end
      6'd43: begin
        w_use_rs      = 1'b1;
        w_use_rt      = 1'b1;
        w_dec.mem_wr  = 1'b1;
        w_dec.use_imm = 1'b1;
      end
      6'd4: begin
        w_use_rs     = 1'b1;
        w_use_rt     = 1'b1;
        w_dec.branch = 1'b1;
      end
      6'd2: w_jump = 1'b1;
`ifdef IMM_ALU_EN
      6'd8, 6'd10, 6'd12, 6'd13: begin
        w_use_rs      = 1'b1;
        w_wr          = 1'b1;
        w_dec.use_imm = 1'b1;
        case (w_op)
          6'd10: w_dec.alu_op = c_ALU_SLT;
          6'd12: begin
            w_dec.alu_op = c_ALU_AND;
            w_dec.imm    = {16'd0, w_imm};
          end
          6'd13: begin
            w_dec.alu_op = c_ALU_OR;
            w_dec.imm    = {16'd0, w_imm};
          end
          default: w_dec.alu_op = c_ALU_ADD;
        endcase
      end
`endif
      default: ;
    endcase
    // Writes to r0 are dropped here so forwarding never matches r0
    w_dec.reg_wr = w_wr && (w_dec.dst != 5'd0);
  end

  assign w_stall = r_idex.mem_rd && r_idex.reg_wr &&
                   ((w_use_rs && w_rs == r_idex.dst) || (w_use_rt && w_rt == r_idex.dst));

  // Jump keeps the upper PC bits of the jump instruction itself
  assign w_jpc     = r_ifid_pc1 - PC_W'(1);
  assign w_jpc32   = 32'(w_jpc);
  assign w_jtarget = PC_W'((w_jpc32 & 32'hFC00_0000) | {6'd0, r_ifid_instr[25:0]});

  // ---------------- EX: forwarding (EX/MEM wins), ALU, branch resolve
  always_comb begin
    if (r_exmem.reg_wr && r_exmem.dst == r_idex.rs)      w_fwd_a = r_exmem.alu_res;
    else if (r_memwb.reg_wr && r_memwb.dst == r_idex.rs) w_fwd_a = r_memwb.wb_val;
    else                                                 w_fwd_a = r_idex.rs_val;
    if (r_exmem.reg_wr && r_exmem.dst == r_idex.rt)      w_fwd_b = r_exmem.alu_res;
    else if (r_memwb.reg_wr && r_memwb.dst == r_idex.rt) w_fwd_b = r_memwb.wb_val;
    else                                                 w_fwd_b = r_idex.rt_val;
    w_alu_b = r_idex.use_imm ? r_idex.imm : w_fwd_b;
    case (r_idex.alu_op)
      c_ALU_SUB: w_alu_res = w_fwd_a - w_alu_b;
      c_ALU_AND: w_alu_res = w_fwd_a & w_alu_b;
      c_ALU_OR:  w_alu_res = w_fwd_a | w_alu_b;
      c_ALU_SLT: w_alu_res = ($signed(w_fwd_a) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
      default:   w_alu_res = w_fwd_a + w_alu_b;
    endcase
  end

  assign w_take    = r_idex.branch && (w_fwd_a == w_fwd_b);
  assign w_btarget = r_idex.pc1 + PC_W'(r_idex.imm);
  assign w_jump_go = w_jump && !w_take;

  assign w_mem_rdata = r_dmem[r_exmem.alu_res[c_DMEM_AW-1:0]];

  // ---------------- pipeline registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_pc         <= '0;
      r_ifid_instr <= '0;
      r_ifid_pc1   <= '0;
      r_idex       <= '0;
      r_exmem      <= '0;
      r_memwb      <= '0;
    end else begin
      if (w_take)         r_pc <= w_btarget;
      else if (w_stall)   r_pc <= r_pc;
      else if (w_jump_go) r_pc <= w_jtarget;
      else                r_pc <= r_pc + PC_W'(1);

      if (w_take || w_jump_go) begin
        r_ifid_instr <= '0;
        r_ifid_pc1   <= '0;
      end else if (!w_stall) begin
        r_ifid_instr <= instruction_i;
        r_ifid_pc1   <= r_pc + PC_W'(1);
      end

      r_idex <= (w_take || w_stall) ? idex_t'('0) : w_dec;

      r_exmem.reg_wr    <= r_idex.reg_wr;
      r_exmem.mem_rd    <= r_idex.mem_rd;
      r_exmem.mem_wr    <= r_idex.mem_wr;
      r_exmem.dst       <= r_idex.dst;
      r_exmem.alu_res   <= w_alu_res;
      r_exmem.store_val <= w_fwd_b;

      r_memwb.reg_wr <= r_exmem.reg_wr;
      r_memwb.dst    <= r_exmem.dst;
      r_memwb.wb_val <= r_exmem.mem_rd ? w_mem_rdata : r_exmem.alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (r_memwb.reg_wr) begin
      r_regs[r_memwb.dst] <= r_memwb.wb_val;
    end
  end

  // Data memory has no reset; contents survive rst_n
  always_ff @(posedge clk) begin
    if (!rst_n && r_exmem.mem_wr) begin
      r_dmem[r_exmem.alu_res[c_DMEM_AW-1:0]] <= r_exmem.store_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips32_5stage_core.sv
`default_nettype none
// =============================================================================
// Module   : tb_mips32_5stage_core
// Brief    : Directed and random-program bench for mips32_5stage_core against
//            an instruction-level reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mips32_5stage_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] pc_addr;

  logic [31:0] rom    [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [32];
  int          n_checks;
  int          n_fail;

`ifdef IMM_ALU_EN
  localparam logic [31:0] c_EXP_R8 = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] c_EXP_R8 = 32'h0000_0000;
`endif

  mips32_5stage_core #(
    .DMEM_DEPTH(32),
    .PC_W      (32)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .instruction_i              (instr),
    .inst_mem_rd_addr_to_instmem(pc_addr)
  );

  assign instr = (pc_addr < 32'd256) ? rom[pc_addr[7:0]] : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    return {6'd2, 26'(target)};
  endfunction

  function automatic logic [31:0] reg_or();
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.r_regs[i];
    return acc;
  endfunction

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
  endtask

  // Holds the core in reset for at least one edge so no store can race the preload
  task automatic begin_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_rom();
  endtask

  task automatic end_reset();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    dut.r_dmem[idx] <= v;
    m_dmem[idx] = v;
  endtask

  // Sequential ISA reference: one instruction at a time, no pipeline notion
  task automatic run_model(input int len);
    int          pc;
    int          npc;
    int          steps;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] simm;
    logic [31:0] zimm;
    logic [5:0]  op;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    pc    = 0;
    steps = 0;
    while (pc < len && steps < 1000) begin
      ins  = rom[pc];
      op   = ins[31:26];
      a    = m_regs[ins[25:21]];
      b    = m_regs[ins[20:16]];
      simm = {{16{ins[15]}}, ins[15:0]};
      zimm = {16'd0, ins[15:0]};
      npc  = pc + 1;
      case (op)
        6'd0: begin
          case (ins[5:0])
            6'h20: m_regs[ins[15:11]] = a + b;
            6'h22: m_regs[ins[15:11]] = a - b;
            6'h24: m_regs[ins[15:11]] = a & b;
            6'h25: m_regs[ins[15:11]] = a | b;
            6'h2A: m_regs[ins[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ;
          endcase
        end
        6'd35: m_regs[ins[20:16]] = m_dmem[(a + simm) & 32'd31];
        6'd43: m_dmem[(a + simm) & 32'd31] = b;
        6'd4:  if (a == b) npc = pc + 1 + int'($signed(simm));
        6'd2:  npc = int'((32'(pc) & 32'hFC00_0000) | {6'd0, ins[25:0]});
`ifdef IMM_ALU_EN
        6'd8:  m_regs[ins[20:16]] = a + simm;
        6'd10: m_regs[ins[20:16]] = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0;
        6'd12: m_regs[ins[20:16]] = a & zimm;
        6'd13: m_regs[ins[20:16]] = a | zimm;
`endif
        default: ;
      endcase
      m_regs[0] = '0;
      pc = npc;
      steps++;
    end
  endtask

  task automatic gen_program(input int len);
    logic [5:0] functs [5];
    logic [5:0] imm_ops [4];
    int kind, rs, rt, rd;
    functs  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    imm_ops = '{6'd8, 6'd10, 6'd12, 6'd13};
    for (int k = 0; k < len; k++) begin
      kind = $urandom_range(0, 9);
      rs   = $urandom_range(0, 7);
      rt   = $urandom_range(0, 7);
      rd   = $urandom_range(0, 7);
      case (kind)
        3:       rom[k] = enc_i(35, rs, rt, $urandom_range(0, 63));
        4:       rom[k] = enc_i(43, rs, rt, $urandom_range(0, 63));
        5:       rom[k] = enc_i(4, rs, rt, $urandom_range(0, 3));
        6:       rom[k] = enc_j(k + 1 + $urandom_range(0, 3));
        7:       rom[k] = enc_i(imm_ops[$urandom_range(0, 3)], rs, rt, $urandom_range(0, 65535));
        8:       rom[k] = ($urandom_range(0, 1) == 1) ? enc_r(rs, rt, rd, 6'h21) : enc_i(6'h3F, rs, rt, 5);
        default: rom[k] = enc_r(rs, rt, rd, functs[$urandom_range(0, 4)]);
      endcase
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    clear_rom();

    // Reset state
    begin_reset();
    end_reset();
    check_value("reset pc", pc_addr, 32'd0);
    check_value("reset regs", reg_or(), 32'd0);

    // Loads, add, not-taken beq, store
    begin_reset();
    preload(0, 32'd1); preload(1, 32'd5); preload(2, 32'd5);
    rom[0] = enc_i(35, 0, 1, 0);
    rom[1] = enc_i(35, 0, 2, 1);
    rom[2] = enc_i(35, 0, 4, 2);
    rom[3] = enc_r(1, 2, 3, 6'h20);
    rom[4] = enc_i(4, 4, 3, -5);
    rom[5] = enc_i(43, 0, 3, 3);
    end_reset();
    run_cycles(7);
    check_value("linear pc after beq not taken", pc_addr, 32'd7);
    run_cycles(13);
    check_value("lw r1", dut.r_regs[1], 32'd1);
    check_value("lw r2", dut.r_regs[2], 32'd5);
    check_value("lw r4", dut.r_regs[4], 32'd5);
    check_value("add r3", dut.r_regs[3], 32'd6);
    check_value("sw dmem3", dut.r_dmem[3], 32'd6);

    // Taken branch back to 0; the two slots after beq never write
    begin_reset();
    preload(0, 32'd1); preload(1, 32'd5); preload(2, 32'd6);
    rom[0] = enc_i(35, 0, 1, 0);
    rom[1] = enc_i(35, 0, 2, 1);
    rom[2] = enc_i(35, 0, 4, 2);
    rom[3] = enc_r(1, 2, 3, 6'h20);
    rom[4] = enc_i(4, 4, 3, -5);
    rom[5] = enc_r(1, 1, 10, 6'h20);
    rom[6] = enc_r(1, 1, 11, 6'h20);
    end_reset();
    run_cycles(6);
    check_value("pc before redirect", pc_addr, 32'd6);
    run_cycles(1);
    check_value("pc after taken beq", pc_addr, 32'd0);
    run_cycles(7);
    check_value("pc after second loop", pc_addr, 32'd0);
    run_cycles(6);
    check_value("flushed slot r10", dut.r_regs[10], 32'd0);
    check_value("flushed slot r11", dut.r_regs[11], 32'd0);
    check_value("loop r3", dut.r_regs[3], 32'd6);

    // Back-to-back forwarding, no stall
    begin_reset();
    preload(0, 32'd1); preload(1, 32'd5);
    rom[0] = enc_i(35, 0, 1, 0);
    rom[1] = enc_i(35, 0, 2, 1);
    rom[3] = enc_r(1, 2, 5, 6'h20);
    rom[4] = enc_r(5, 1, 6, 6'h22);
    rom[5] = enc_r(5, 6, 7, 6'h25);
    end_reset();
    run_cycles(6);
    check_value("no-stall pc", pc_addr, 32'd6);
    run_cycles(8);
    check_value("fwd r5", dut.r_regs[5], 32'd6);
    check_value("fwd r6", dut.r_regs[6], 32'd5);
    check_value("fwd r7", dut.r_regs[7], 32'd7);

    // Load-use: one stall cycle
    begin_reset();
    preload(0, 32'd7);
    rom[0] = enc_i(35, 0, 1, 0);
    rom[1] = enc_r(1, 1, 3, 6'h20);
    end_reset();
    run_cycles(4);
    check_value("load-use stalled pc", pc_addr, 32'd3);
    run_cycles(8);
    check_value("load-use r3", dut.r_regs[3], 32'd14);

    // Jump to 0x10, slot after j squashed
    begin_reset();
    preload(0, 32'd1);
    rom[0]     = enc_i(35, 0, 1, 0);
    rom[1]     = enc_j(32'h10);
    rom[2]     = enc_r(1, 1, 9, 6'h20);
    rom[32'h10] = enc_r(1, 1, 12, 6'h20);
    end_reset();
    run_cycles(2);
    check_value("pc at j slot", pc_addr, 32'd2);
    run_cycles(1);
    check_value("pc after j", pc_addr, 32'h10);
    run_cycles(10);
    check_value("j slot r9", dut.r_regs[9], 32'd0);
    check_value("j target r12", dut.r_regs[12], 32'd2);

    // Mid-run reset discards in-flight work
    begin_reset();
    preload(0, 32'd1);
    rom[0]     = enc_i(35, 0, 1, 0);
    rom[1]     = enc_j(32'h10);
    rom[32'h10] = enc_r(1, 1, 12, 6'h20);
    end_reset();
    run_cycles(3);
    clear_rom();
    rst_n = 1'b1;
    run_cycles(1);
    check_value("mid-run reset pc", pc_addr, 32'd0);
    check_value("mid-run reset regs", reg_or(), 32'd0);
    rst_n = 1'b0;
    run_cycles(8);
    check_value("no in-flight write after reset", reg_or(), 32'd0);
    check_value("pc restarts after reset", pc_addr, 32'd8);

    // Immediate ALU option
    begin_reset();
    rom[0] = enc_i(8, 0, 8, -1);
    end_reset();
    run_cycles(8);
    check_value("addi r8", dut.r_regs[8], c_EXP_R8);

    // Random forward-flowing programs against the reference model
    for (int p = 0; p < 8; p++) begin
      begin_reset();
      for (int i = 0; i < 32; i++) preload(i, $urandom);
      gen_program(24);
      end_reset();
      run_model(24);
      run_cycles(100);
      for (int i = 0; i < 32; i++)
        check_value($sformatf("prog%0d r%0d", p, i), dut.r_regs[i], m_regs[i]);
      for (int i = 0; i < 32; i++)
        check_value($sformatf("prog%0d dmem%0d", p, i), dut.r_dmem[i], m_dmem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
